// File: rtl/truth_table_scanner_if.sv
// ============================================================================
// Module   : truth_table_scanner_if
// Purpose  : Host/function-side bundle of the truth-table scanner.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface truth_table_scanner_if;
   logic        start;
   logic        abort;
   logic        f_in;
   logic        a;
   logic        b;
   logic        c;
   logic        d;
   logic        en_out;
   logic        busy;
   logic        done;
   logic [15:0] table_out;
   logic [4:0]  ones_cnt;

   modport master (
      output start, abort, f_in,
      input  a, b, c, d, en_out, busy, done, table_out, ones_cnt
   );

   modport slave (
      input  start, abort, f_in,
      output a, b, c, d, en_out, busy, done, table_out, ones_cnt
   );
endinterface

`default_nettype wire

// File: rtl/truth_table_scanner.sv
// ============================================================================
// Module   : truth_table_scanner
// Purpose  : Sweeps a 4-input function through all 16 codes and records its
//            truth table plus the count of 1 minterms.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module truth_table_scanner #(
   parameter int SETTLE = 2
) (
   input  wire logic            clk,
   input  wire logic            rst_n,
   truth_table_scanner_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DRIVE  = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_FINISH = 2'd3
   } state_t;

   localparam logic [3:0] c_settle_last = 4'(SETTLE - 1);

   state_t      r_state;
   logic [3:0]  r_index;
   logic [3:0]  r_settle;
   logic [15:0] r_table;
   logic [4:0]  r_ones;
   logic        r_busy;
   logic        r_en;
   logic        r_done;

   // Index is forced to 0 on every exit from DRIVE/SAMPLE, so it can feed
   // the code outputs directly and still read 0 outside a scan.
   assign bus.a         = r_index[3];
   assign bus.b         = r_index[2];
   assign bus.c         = r_index[1];
   assign bus.d         = r_index[0];
   assign bus.en_out    = r_en;
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.table_out = r_table;
   assign bus.ones_cnt  = r_ones;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_index  <= 4'd0;
         r_settle <= 4'd0;
         r_table  <= 16'd0;
         r_ones   <= 5'd0;
         r_busy   <= 1'b0;
         r_en     <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.start) begin
                  r_state  <= ST_DRIVE;
                  r_index  <= 4'd0;
                  r_settle <= 4'd0;
                  r_table  <= 16'd0;
                  r_ones   <= 5'd0;
                  r_busy   <= 1'b1;
                  r_en     <= 1'b1;
               end
            end

            ST_DRIVE: begin
               if (bus.abort) begin
                  r_state  <= ST_IDLE;
                  r_index  <= 4'd0;
                  r_settle <= 4'd0;
                  r_busy   <= 1'b0;
                  r_en     <= 1'b0;
               end else begin
                  r_settle <= r_settle + 4'd1;
                  if (r_settle == c_settle_last) begin
                     r_state <= ST_SAMPLE;
                  end
               end
            end

            ST_SAMPLE: begin
               // Abort wins over the sample: the current code is not recorded.
               if (bus.abort) begin
                  r_state  <= ST_IDLE;
                  r_index  <= 4'd0;
                  r_settle <= 4'd0;
                  r_busy   <= 1'b0;
                  r_en     <= 1'b0;
               end else begin
                  r_table[r_index] <= bus.f_in;
                  r_ones           <= r_ones + 5'(bus.f_in);
                  r_settle         <= 4'd0;
                  if (r_index == 4'd15) begin
                     r_state <= ST_FINISH;
                     r_index <= 4'd0;
                     r_busy  <= 1'b0;
                     r_en    <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= ST_DRIVE;
                     r_index <= r_index + 4'd1;
                  end
               end
            end

            ST_FINISH: begin
               r_state <= ST_IDLE;
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: doc/truth_table_scanner.md
# truth_table_scanner

- Controller that sequences the 4-input function block (4x16 decoder plus OR-plane, inputs `a,b,c,d`, output `o`) through all 16 input codes.
- For each code it waits a programmable settle time, then samples `o` into a 16-bit truth-table register.
- It also reports how many minterms are 1.
- It sits between a host or bench controller and the combinational function, replacing hand-written stimulus sweeps with a start/busy/done handshake.

## Interface
Parameters:
- `SETTLE`, default 2: cycles each code is held before its sample cycle. Legal range 1..15.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: request a full scan; sampled only in IDLE.
- `abort` in 1: synchronous cancel of a running scan.
- `f_in` in 1: function output (`o` of the function block).
- `a`, `b`, `c`, `d` out 1 each: code driven to the function block; `a` is the MSB, {a,b,c,d} = current index.
- `en_out` out 1: decoder enable; high only while a code is being driven.
- `busy` out 1: scan in progress.
- `done` out 1: one-cycle pulse when a scan completes normally.
- `table_out` out 16: bit k = sampled `f_in` for code k.
- `ones_cnt` out 5: number of 1 bits in `table_out` (0..16).

## Operation
States:
- **IDLE**
  - `en_out`=0, `busy`=0, `{a,b,c,d}`=0.
  - `start`=1 → DRIVE. At that same edge: index=0, settle counter=0, `table_out`=0, `ones_cnt`=0.
- **DRIVE**
  - `en_out`=1, `busy`=1, `{a,b,c,d}`=index.
  - Settle counter increments each cycle. Once it has counted `SETTLE` cycles → SAMPLE.
- **SAMPLE**
  - Outputs as in DRIVE.
  - At the exit edge: `table_out[index]` ← `f_in`, and `ones_cnt` += `f_in`.
  - If index < 15: index+1, settle counter=0 → DRIVE.
  - If index = 15 → FINISH.
- **FINISH**
  - One cycle: `done`=1, `busy`=0, `en_out`=0, `{a,b,c,d}`=0.
  - → IDLE unconditionally.
  - `start` in FINISH is ignored.

Rules:
- `start` while `busy` is ignored; there is no queuing.
- `abort`=1 in DRIVE or SAMPLE → IDLE at the next edge.
  - The sample for the current code is not taken.
  - `table_out` and `ones_cnt` keep their partial values.
  - `done` is not asserted.
- `abort` in IDLE or FINISH has no effect.
- `abort` has priority over the SAMPLE-exit update.
- `table_out` and `ones_cnt` hold after `done` until the next accepted `start`.
- `ones_cnt` is 5 bits so that 16 is representable; it never wraps.
- Index is 4 bits. The 15→0 wrap never occurs inside a scan, because index 15 exits to FINISH.

## Timing
- Reset (`rst_n`=0 at an edge): state IDLE, and every output is 0 (`a..d`, `en_out`, `busy`, `done`, `table_out`, `ones_cnt`, plus the internal index and settle counter). Reset mid-scan aborts with all outputs cleared.
- Let start-accept edge E0 be the edge where IDLE sees `start`.
- `busy`, `en_out` and code 0 appear in the cycle after E0.
- Each code is held for exactly `SETTLE`+1 cycles (`SETTLE` DRIVE + 1 SAMPLE). `f_in` is sampled at the end of the last held cycle.
- `busy` is high for 16×(`SETTLE`+1) cycles. With the default of 2 this is 48 cycles.
- `done` is high in cycle 16×(`SETTLE`+1)+1 after E0, which is cycle 49 by default.
- The earliest next start-accept edge is the one ending the first IDLE cycle after FINISH. Back-to-back scans are therefore separated by one FINISH cycle and one IDLE cycle.
- `f_in` must be stable from `SETTLE` cycles after a code change until the sample edge.

## Test plan
- **Parity scan:** `SETTLE`=2, with a model `f_in` = a^b^c^d.
  - Pulse `start`.
  - Required: `busy` high for 48 cycles, then a single `done` pulse.
  - Required: `table_out`=16'h6996, `ones_cnt`=8.
  - Required: `{a,b,c,d}` steps 0..15, each code held 3 cycles.
- **Constant inputs:** `f_in`=0 gives `table_out`=16'h0000, `ones_cnt`=0. `f_in`=1 gives 16'hFFFF, `ones_cnt`=16. The two scans are run back to back, and the second `table_out` begins cleared.
- **Abort:** with `f_in`=1, assert `abort` while code 5 is in DRIVE.
  - Required: IDLE at the next edge, `en_out`=0, `done` never asserted.
  - Required: `table_out`=16'h001F, `ones_cnt`=5.
- **Start while busy:** pulse `start` at cycles 10 and 30 of a scan.
  - Required: scan length is unchanged (48 cycles) and only one `done` occurs.
  - Required: a `start` in the FINISH cycle is ignored.
- **Reset mid-scan:** drive `rst_n`=0 for one edge at code 9.
  - Required: all outputs are 0 at the next cycle, and the state is IDLE.
  - Required: a subsequent `start` runs a complete, correct scan.
- **Minimum settle:** `SETTLE`=1, with a model `f_in` = (code==4'hA).
  - Required: each code is held 2 cycles and `busy` lasts 32 cycles.
  - Required: `table_out`=16'h0400, `ones_cnt`=1.
